ripple_borrow_subtractor_28b: RTL
=================================

RIPPLE_BORROW_SUBTRACTOR_28B -- requirements
Module: ripple_borrow_subtractor_28b

Interface
REQ-001 The block SHALL use parameter WIDTH, default 28, as the operand and difference width.
REQ-002 The block SHALL use parameter SLICE, default 7, as the bits resolved per CALC cycle; WIDTH SHALL be a multiple of SLICE.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 a  input  WIDTH  minuend; captured on the accepted start.
REQ-008 b  input  WIDTH  subtrahend; captured on the accepted start.
REQ-009 b_in  input  1  borrow-in; captured on the accepted start.
REQ-010 diff  output  WIDTH  registered difference a - b - b_in, modulo 2^WIDTH.
REQ-011 b_out  output  1  registered borrow-out; 1 when a < b + b_in.
REQ-012 busy  output  1  high in CALC and DONE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL capture a, b and b_in, clear the slice counter, and move to CALC.
REQ-016 In CALC, each edge SHALL resolve slice[cnt] with a SLICE-bit ripple-borrow chain fed by the stored borrow, store the slice result in a shadow register, store the slice borrow-out, and increment cnt.
REQ-017 The borrow into slice 0 SHALL be the captured b_in.
REQ-018 When the last slice is resolved (cnt = WIDTH/SLICE-1), the block SHALL copy the shadow register to diff, set b_out to the final borrow, and move to DONE; both updates SHALL happen on the same edge.
REQ-019 diff and b_out SHALL hold their previous result during CALC and SHALL change only on the completion edge.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-021 Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge E0+WIDTH/SLICE (E0+4 for the defaults), and the block SHALL re-enter IDLE at E0+5.
REQ-022 start SHALL be ignored in CALC and DONE, and captured operands SHALL NOT change while busy=1.
REQ-023 A start at the edge that enters IDLE from DONE SHALL be ignored; the earliest accepted back-to-back start SHALL be at E0+6.
REQ-024 diff and b_out SHALL hold the last result indefinitely in IDLE.
REQ-025 Internal arithmetic SHALL be a bit-serial ripple-borrow chain per slice: d = x^y^bi, bo = (~x&y) | (~(x^y)&bi).

Reset
REQ-026 When rstn=0, the block SHALL go to IDLE immediately, regardless of clk.
REQ-027 On reset, diff, b_out, busy, done, cnt, the captured operands, the shadow register and the stored borrow SHALL all be 0.
REQ-028 Reset asserted during CALC or DONE SHALL abort the operation; no done pulse SHALL follow and no partial result SHALL reach diff.
REQ-029 After rstn deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-030 Reset: assert rstn=0 mid-cycle -> diff=0, b_out=0, busy=0 and done=0 immediately, without waiting for a clock edge.
REQ-031 Basic: a=28'h0000005, b=28'h0000003, b_in=0 -> diff=28'h0000002, b_out=0, done at E0+4, busy high E0..E0+4.
REQ-032 Full borrow ripple: a=0, b=1, b_in=0 -> diff=28'hFFFFFFF, b_out=1; additionally, diff keeps its prior value until E0+4.
REQ-033 Inter-slice borrow: a=28'h0000080, b=28'h0000001 -> diff=28'h000007F, b_out=0; and a=28'hFFFFFFF, b=28'hFFFFFFF, b_in=1 -> diff=28'hFFFFFFF, b_out=1.
REQ-034 Start while busy: start with a=10, b=4; re-pulse start with a=1, b=9 at E0+2 -> diff=28'h0000006, b_out=0, exactly one done pulse.
REQ-035 Reset mid-op: start a=100, b=1; pull rstn low at E0+2, release, then start a=9, b=2 -> no done before the second start, then diff=28'h0000007 and one done pulse.

Source files
------------

// File: rtl/ripple_borrow_subtractor_28b.sv
// ripple_borrow_subtractor_28b: multi-cycle subtractor resolving SLICE bits per cycle
// with a ripple-borrow chain; result and borrow-out publish together on completion.
module ripple_borrow_subtractor_28b #(
    parameter int WIDTH = 28,
    parameter int SLICE = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             busy,
    output logic             done
);
    localparam int NSL = WIDTH / SLICE;
    localparam int CW = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, shadow_q, shadow_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic brw_q, brw_d, b_out_q, b_out_d;
    logic [SLICE-1:0] x, y, s;
    logic bi;
    int base;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            b_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            b_out_q  <= b_out_d;
        end
    end

    always_comb begin
        case (state_q)
            IDLE:    state_d = start ? CALC : IDLE;
            CALC:    state_d = (cnt_q == LAST) ? DONE : CALC;
            default: state_d = IDLE;
        endcase
    end

    // Bit-serial borrow chain over the slice selected by cnt, seeded by the stored borrow.
    always_comb begin
        base = int'(cnt_q) * SLICE;
        x = a_q[base +: SLICE];
        y = b_q[base +: SLICE];
        s = '0;
        bi = brw_q;
        for (int i = 0; i < SLICE; i++) begin
            s[i] = x[i] ^ y[i] ^ bi;
            bi = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bi);
        end
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        if (state_q == IDLE && start) begin
            a_d   = a;
            b_d   = b;
            brw_d = b_in;
            cnt_d = '0;
        end else if (state_q == CALC) begin
            shadow_d[base +: SLICE] = s;
            brw_d = bi;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                diff_d  = shadow_d;
                b_out_d = bi;
            end
        end
    end

    always_comb begin
        busy  = state_q != IDLE;
        done  = state_q == DONE;
        diff  = diff_q;
        b_out = b_out_q;
    end
endmodule
